branch_predictor: RTL

- Parametrised gshare branch predictor with a direct-mapped branch target buffer (BTB) for the 5-stage pipelined RV32 core.
- Sits beside the PC in IF and gives a zero-latency next-PC prediction.
- Trained by the resolved outcome from EX.
- Successor to the fixed PC+4 fetch path. Lets the pipeline handle conditional branches and JAL/JALR without always flushing.

---
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side lookup and EX-side training signals of the
// gshare/BTB branch predictor, bundled so the core and the predictor agree on
// widths in one place.
//   master : core side   - drives pc and the upd_* training fields,
//                          consumes pred_taken / pred_next_pc / pred_ghr.
//   slave  : predictor   - the mirror image.
interface branch_predictor_if #(
  parameter int XLEN     = 32,
  parameter int GHR_BITS = 6
);
  // Lookup (IF)
  logic [XLEN-1:0]     pc;
  logic                pred_taken;
  logic [XLEN-1:0]     pred_next_pc;
  logic [GHR_BITS-1:0] pred_ghr;

  // Training (EX)
  logic                upd_valid;
  logic [XLEN-1:0]     upd_pc;
  logic                upd_is_branch;
  logic                upd_taken;
  logic [XLEN-1:0]     upd_target;
  logic [GHR_BITS-1:0] upd_ghr;

  modport master (
    output pc,
    output upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target, upd_ghr,
    input  pred_taken, pred_next_pc, pred_ghr
  );

  modport slave (
    input  pc,
    input  upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target, upd_ghr,
    output pred_taken, pred_next_pc, pred_ghr
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: gshare direction predictor plus a direct-mapped branch
// target buffer. Lookup is purely combinational from the fetch PC; training
// happens on the clock edge from the resolved instruction in EX.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; clears BTB valid bits, sets every
//            counter to weakly not-taken, clears the global history
//   bp     : branch_predictor_if.slave
//            pc -> pred_taken, pred_next_pc, pred_ghr   (0-cycle lookup)
//            upd_valid/upd_pc/upd_is_branch/upd_taken/upd_target/upd_ghr
//                                                     (training on posedge)
module branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int BHT_ENTRIES = 64,
  parameter int GHR_BITS    = 6
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);

  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W     = XLEN - 2 - BTB_IDX_W;

  localparam logic [1:0] CTR_MAX  = 2'b11;
  localparam logic [1:0] CTR_MIN  = 2'b00;
  localparam logic [1:0] CTR_INIT = 2'b01;

  // BTB storage
  logic [BTB_ENTRIES-1:0]             btb_valid;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]  btb_tag;
  logic [BTB_ENTRIES-1:0][XLEN-1:0]   btb_target;
  logic [BTB_ENTRIES-1:0]             btb_uncond;

  // Pattern history table and global history
  logic [BHT_ENTRIES-1:0][1:0]        bht;
  logic [GHR_BITS-1:0]                ghr;

  // Lookup path
  logic [BTB_IDX_W-1:0] lk_btb_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic [BHT_IDX_W-1:0] lk_bht_idx;
  logic                 lk_hit;
  logic [XLEN-1:0]      lk_seq_pc;

  // Update path
  logic [BTB_IDX_W-1:0] up_btb_idx;
  logic [TAG_W-1:0]     up_tag;
  logic [BHT_IDX_W-1:0] up_bht_idx;
  logic [1:0]           up_ctr;
  logic [1:0]           up_ctr_next;
  logic [GHR_BITS-1:0]  ghr_next;

  // Instruction-aligned PCs: the two LSBs carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = &{1'b0, bp.pc[1:0], bp.upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  assign lk_btb_idx = bp.pc[2 +: BTB_IDX_W];
  assign lk_tag     = bp.pc[XLEN-1 : 2+BTB_IDX_W];
  // GHR is narrower than (or equal to) the index, so it is zero-extended.
  assign lk_bht_idx = bp.pc[2 +: BHT_IDX_W] ^ BHT_IDX_W'(ghr);
  assign lk_seq_pc  = bp.pc + XLEN'(4);

  always_comb begin
    lk_hit          = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
    bp.pred_taken   = 1'b0;
    bp.pred_next_pc = lk_seq_pc;
    bp.pred_ghr     = ghr;
    // Unconditional jumps redirect on any hit; branches need the counter MSB.
    if (lk_hit && (btb_uncond[lk_btb_idx] || bht[lk_bht_idx][1])) begin
      bp.pred_taken   = 1'b1;
      bp.pred_next_pc = btb_target[lk_btb_idx];
    end
  end

  // ---------------------------------------------------------------- update
  assign up_btb_idx = bp.upd_pc[2 +: BTB_IDX_W];
  assign up_tag     = bp.upd_pc[XLEN-1 : 2+BTB_IDX_W];
  // Train the counter that was consulted at lookup time, using the history
  // snapshot carried down the pipeline rather than the current GHR.
  assign up_bht_idx = bp.upd_pc[2 +: BHT_IDX_W] ^ BHT_IDX_W'(bp.upd_ghr);
  assign up_ctr     = bht[up_bht_idx];

  always_comb begin
    up_ctr_next = up_ctr;
    if (bp.upd_taken) begin
      if (up_ctr != CTR_MAX) up_ctr_next = up_ctr + 2'd1;
    end else begin
      if (up_ctr != CTR_MIN) up_ctr_next = up_ctr - 2'd1;
    end
  end

  // Shift in the outcome; truncation drops the oldest bit and also covers
  // the single-bit history case without a zero-width slice.
  assign ghr_next = GHR_BITS'({ghr, bp.upd_taken});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid  <= '0;
      btb_tag    <= '0;
      btb_target <= '0;
      btb_uncond <= '0;
      bht        <= {BHT_ENTRIES{CTR_INIT}};
      ghr        <= '0;
    end else if (bp.upd_valid) begin
      // Only taken outcomes allocate; not-taken never evicts an entry.
      if (bp.upd_taken) begin
        btb_valid[up_btb_idx]  <= 1'b1;
        btb_tag[up_btb_idx]    <= up_tag;
        btb_target[up_btb_idx] <= bp.upd_target;
        btb_uncond[up_btb_idx] <= ~bp.upd_is_branch;
      end
      // JAL/JALR leave direction state alone.
      if (bp.upd_is_branch) begin
        bht[up_bht_idx] <= up_ctr_next;
        ghr             <= ghr_next;
      end
    end
  end

endmodule
